// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, press/release pulses and LED toggle.
// Define BTN_LONG_PRESS_EN to add the hold counter that drives long_press; otherwise long_press is tied low.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20,
  parameter int LONG_CYCLES     = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle_led,
  output logic long_press
);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES out of range");
  end
  if (LONG_CYCLES < 1 || longint'(LONG_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_long
    $error("btn_debounce: LONG_CYCLES out of range");
  end

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES+1 consecutive agreeing sync2 samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STABLE_LO;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle_led    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync2) begin
            state <= WAIT_HI;
            cnt   <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync2) begin
            state <= STABLE_LO;
          end else if (cnt == CNT_LAST) begin
            state       <= STABLE_HI;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            toggle_led  <= ~toggle_led;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync2) begin
            state <= WAIT_LO;
            cnt   <= '0;
          end
        end
        WAIT_LO: begin
          if (sync2) begin
            state <= STABLE_HI;
          end else if (cnt == CNT_LAST) begin
            state         <= STABLE_LO;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             long_fired;

  // Hold counter restarts only on an accepted press, so a WAIT_LO bounce keeps the count going.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      long_fired <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (state == WAIT_HI && sync2 && cnt == CNT_LAST) begin
        hold_cnt   <= '0;
        long_fired <= 1'b0;
      end else if (state == STABLE_HI || state == WAIT_LO) begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end else if (!long_fired) begin
          long_press <= 1'b1;
          long_fired <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule
